// File: rtl/vlsu_txn_issuer.sv
// -----------------------------------------------------------------------------
// vlsu_txn_issuer
//
// Purpose:
//   Breaks a vector load/store segment descriptor into page-sized transaction
//   requests. A descriptor gives a nibble-granular base address, the number of
//   transactions minus one, and the end nibble count of the last transaction.
//   The issuer emits one transaction per cycle while downstream is ready. Each
//   transaction carries a page-aligned address, the first valid nibble offset,
//   the valid nibble count and last/final flags.
//
// Parameters:
//   VLSU_ADDR_BITS - nibble address width
//   SLEN           - page width in bits (P = SLEN/4 nibbles, NB = log2(P))
//   TXN_BITS       - transaction index width
//
// Ports:
//   clock          in   single clock, rising edge
//   reset          in   asynchronous, active-high reset
//   seg_valid      in   segment descriptor valid
//   seg_ready      out  descriptor accepted this cycle
//   seg_base_addr  in   segment base nibble address
//   seg_txn_num    in   transactions in segment minus one
//   seg_ltn        in   last transaction end nibble count (1..P)
//   seg_final      in   segment is the last of the request
//   txn_valid      out  transaction request valid
//   txn_ready      in   downstream accepts the request
//   txn_addr       out  page-aligned nibble address
//   txn_off        out  first valid nibble within the page
//   txn_nbs        out  valid nibble count (1..P)
//   txn_last_seg   out  last transaction of the segment
//   txn_final      out  last transaction of the request
//   busy           out  issuer is not idle
//   stall_cnt      out  (only with VLSU_TXN_STALL_CNT_EN) saturating count of
//                       cycles with txn_valid && !txn_ready
//
// Configuration macro:
//   VLSU_TXN_STALL_CNT_EN - adds the stall_cnt port and its counter.
// -----------------------------------------------------------------------------
module vlsu_txn_issuer #(
    parameter  int unsigned VLSU_ADDR_BITS = 32,
    parameter  int unsigned SLEN           = 512,
    parameter  int unsigned TXN_BITS       = 8,
    localparam int unsigned P              = SLEN / 4,
    localparam int unsigned NB             = $clog2(P)
) (
    input  logic                      clock,
    input  logic                      reset,

    input  logic                      seg_valid,
    output logic                      seg_ready,
    input  logic [VLSU_ADDR_BITS-1:0] seg_base_addr,
    input  logic [TXN_BITS-1:0]       seg_txn_num,
    input  logic [NB:0]               seg_ltn,
    input  logic                      seg_final,

    output logic                      txn_valid,
    input  logic                      txn_ready,
    output logic [VLSU_ADDR_BITS-1:0] txn_addr,
    output logic [NB-1:0]             txn_off,
    output logic [NB:0]               txn_nbs,
    output logic                      txn_last_seg,
    output logic                      txn_final,

    output logic                      busy
`ifdef VLSU_TXN_STALL_CNT_EN
    ,
    output logic [31:0]               stall_cnt
`endif
);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] ISSUE = 1'b1;

    // One full page, as an address increment and as a nibble count.
    localparam logic [VLSU_ADDR_BITS-1:0] ADDR_STEP = VLSU_ADDR_BITS'(P);
    localparam logic [NB:0]               P_NBS     = (NB + 1)'(P);

    logic [0:0]                state_q,     state_d;
    logic [TXN_BITS-1:0]       cnt_q,       cnt_d;
    logic [TXN_BITS-1:0]       num_q,       num_d;
    logic [NB:0]               ltn_q,       ltn_d;
    logic                      seg_final_q, seg_final_d;

    logic [VLSU_ADDR_BITS-1:0] addr_q,      addr_d;
    logic [NB-1:0]             off_q,       off_d;
    logic [NB:0]               nbs_q,       nbs_d;
    logic                      last_q,      last_d;
    logic                      final_q,     final_d;

    logic                      issuing;
    logic                      fire;
    logic                      at_last;
    logic                      accept;
    logic                      load;
    logic [TXN_BITS-1:0]       cnt_inc;
    logic                      next_is_last;
    logic                      seg_single;
    logic [NB-1:0]             seg_off;

    assign issuing      = (state_q == ISSUE);
    assign fire         = issuing && txn_ready;
    assign at_last      = (cnt_q == num_q);
    assign accept       = !issuing || (fire && at_last);
    assign load         = seg_valid && accept;
    assign cnt_inc      = cnt_q + TXN_BITS'(1);
    assign next_is_last = (cnt_inc == num_q);
    assign seg_single   = (seg_txn_num == '0);
    assign seg_off      = seg_base_addr[NB-1:0];

    // Every txn_* field is computed one cycle ahead and held in a register, so
    // nothing on the seg_* side reaches txn_* combinationally and the fields
    // stay put for free while downstream back-pressures.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        num_d       = num_q;
        ltn_d       = ltn_q;
        seg_final_d = seg_final_q;
        addr_d      = addr_q;
        off_d       = off_q;
        nbs_d       = nbs_q;
        last_d      = last_q;
        final_d     = final_q;

        if (load) begin
            // New descriptor: either from IDLE or chained onto the last fire
            // of the previous segment, which avoids an idle bubble.
            state_d     = ISSUE;
            cnt_d       = '0;
            num_d       = seg_txn_num;
            ltn_d       = seg_ltn;
            seg_final_d = seg_final;
            addr_d      = {seg_base_addr[VLSU_ADDR_BITS-1:NB], {NB{1'b0}}};
            off_d       = seg_off;
            nbs_d       = seg_single ? (seg_ltn - {1'b0, seg_off})
                                     : (P_NBS   - {1'b0, seg_off});
            last_d      = seg_single;
            final_d     = seg_single && seg_final;
        end else if (fire && !at_last) begin
            // Advance to the next page; only the first page has an offset.
            cnt_d   = cnt_inc;
            addr_d  = addr_q + ADDR_STEP;
            off_d   = '0;
            nbs_d   = next_is_last ? ltn_q : P_NBS;
            last_d  = next_is_last;
            final_d = next_is_last && seg_final_q;
        end else if (fire) begin
            // Last transaction taken and no follow-on descriptor.
            state_d = IDLE;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            num_q       <= '0;
            ltn_q       <= '0;
            seg_final_q <= 1'b0;
            addr_q      <= '0;
            off_q       <= '0;
            nbs_q       <= '0;
            last_q      <= 1'b0;
            final_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            num_q       <= num_d;
            ltn_q       <= ltn_d;
            seg_final_q <= seg_final_d;
            addr_q      <= addr_d;
            off_q       <= off_d;
            nbs_q       <= nbs_d;
            last_q      <= last_d;
            final_q     <= final_d;
        end
    end

    // seg_ready is held low for the duration of reset so no descriptor can be
    // handed over while the state is being cleared.
    assign seg_ready    = !reset && accept;
    assign txn_valid    = issuing;
    assign busy         = issuing;
    assign txn_addr     = addr_q;
    assign txn_off      = off_q;
    assign txn_nbs      = nbs_q;
    assign txn_last_seg = last_q;
    assign txn_final    = final_q;

`ifdef VLSU_TXN_STALL_CNT_EN
    logic [31:0] stall_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stall_q <= '0;
        end else if (issuing && !txn_ready && (stall_q != '1)) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_vlsu_txn_issuer.sv
module tb_vlsu_txn_issuer;

    localparam int unsigned AW = 32;
    localparam int unsigned TB = 8;
    localparam int unsigned NB = 7;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          seg_valid = 1'b0;
    logic          seg_ready;
    logic [AW-1:0] seg_base_addr = '0;
    logic [TB-1:0] seg_txn_num = '0;
    logic [NB:0]   seg_ltn = '0;
    logic          seg_final = 1'b0;
    logic          txn_valid;
    logic          txn_ready = 1'b0;
    logic [AW-1:0] txn_addr;
    logic [NB-1:0] txn_off;
    logic [NB:0]   txn_nbs;
    logic          txn_last_seg;
    logic          txn_final;
    logic          busy;
`ifdef VLSU_TXN_STALL_CNT_EN
    logic [31:0]   stall_cnt;
`endif

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;

    vlsu_txn_issuer #(
        .VLSU_ADDR_BITS(AW),
        .SLEN          (512),
        .TXN_BITS      (TB)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .seg_valid    (seg_valid),
        .seg_ready    (seg_ready),
        .seg_base_addr(seg_base_addr),
        .seg_txn_num  (seg_txn_num),
        .seg_ltn      (seg_ltn),
        .seg_final    (seg_final),
        .txn_valid    (txn_valid),
        .txn_ready    (txn_ready),
        .txn_addr     (txn_addr),
        .txn_off      (txn_off),
        .txn_nbs      (txn_nbs),
        .txn_last_seg (txn_last_seg),
        .txn_final    (txn_final),
        .busy         (busy)
`ifdef VLSU_TXN_STALL_CNT_EN
        ,
        .stall_cnt    (stall_cnt)
`endif
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total = n_total + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk_txn(input string tag, input logic [31:0] addr, input logic [31:0] off,
                           input logic [31:0] nbs, input logic last, input logic fin);
        chk({tag, ".valid"}, 32'(txn_valid), 32'd1);
        chk({tag, ".addr"},  txn_addr, addr);
        chk({tag, ".off"},   32'(txn_off), off);
        chk({tag, ".nbs"},   32'(txn_nbs), nbs);
        chk({tag, ".last"},  32'(txn_last_seg), 32'(last));
        chk({tag, ".final"}, 32'(txn_final), 32'(fin));
    endtask

    task automatic set_seg(input logic v, input logic [31:0] base, input logic [7:0] num,
                           input logic [7:0] ltn, input logic fin);
        seg_valid     = v;
        seg_base_addr = base;
        seg_txn_num   = num;
        seg_ltn       = ltn;
        seg_final     = fin;
    endtask

    initial begin
        // ---------------- reset state ----------------
        tick();
        chk("rst.valid", 32'(txn_valid), 32'd0);
        chk("rst.busy",  32'(busy), 32'd0);
        chk("rst.ready", 32'(seg_ready), 32'd0);
        chk("rst.addr",  txn_addr, 32'd0);
        chk("rst.off",   32'(txn_off), 32'd0);
        chk("rst.nbs",   32'(txn_nbs), 32'd0);
        chk("rst.last",  32'(txn_last_seg), 32'd0);
        chk("rst.final", 32'(txn_final), 32'd0);
`ifdef VLSU_TXN_STALL_CNT_EN
        chk("rst.stall", stall_cnt, 32'd0);
`endif
        #3 reset = 1'b0;
        #1 chk("idle.ready", 32'(seg_ready), 32'd1);

        // ---------------- single transaction ----------------
        tick();
        txn_ready = 1'b1;
        set_seg(1'b1, 32'h105, 8'd0, 8'h45, 1'b0);
        #1 chk("s1.accept", 32'(seg_ready), 32'd1);
        tick();
        set_seg(1'b0, 32'h0, 8'd0, 8'h0, 1'b0);
        chk_txn("s1.t0", 32'h100, 32'h5, 32'h40, 1'b1, 1'b0);
        chk("s1.busy", 32'(busy), 32'd1);
        #1 chk("s1.lastfire_ready", 32'(seg_ready), 32'd1);
        tick();
        chk("s1.idle_valid", 32'(txn_valid), 32'd0);
        chk("s1.idle_busy",  32'(busy), 32'd0);

        // ---------------- three transactions with a stall ----------------
        set_seg(1'b1, 32'h10A, 8'd2, 8'h20, 1'b1);
        tick();
        set_seg(1'b0, 32'h0, 8'd0, 8'h0, 1'b0);
        chk_txn("s2.t0", 32'h100, 32'h0A, 32'h76, 1'b0, 1'b0);
        #1 chk("s2.t0_ready", 32'(seg_ready), 32'd0);
        tick();
        chk_txn("s2.t1", 32'h180, 32'h0, 32'h80, 1'b0, 1'b0);
        txn_ready = 1'b0;
        // a descriptor offered mid-segment must be ignored
        set_seg(1'b1, 32'hFFF, 8'd5, 8'h11, 1'b0);
        #1 chk("s2.stall_ready", 32'(seg_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_txn("s2.stall", 32'h180, 32'h0, 32'h80, 1'b0, 1'b0);
        end
        set_seg(1'b0, 32'h0, 8'd0, 8'h0, 1'b0);
        txn_ready = 1'b1;
`ifdef VLSU_TXN_STALL_CNT_EN
        chk("s2.stall_cnt", stall_cnt, 32'd3);
`endif
        tick();
        chk_txn("s2.t2", 32'h200, 32'h0, 32'h20, 1'b1, 1'b1);
        #1 chk("s2.t2_ready", 32'(seg_ready), 32'd1);
        tick();
        chk("s2.idle", 32'(txn_valid), 32'd0);

        // ---------------- back-to-back descriptors ----------------
        set_seg(1'b1, 32'h000, 8'd1, 8'h80, 1'b0);
        tick();
        set_seg(1'b1, 32'h3FF, 8'd0, 8'h80, 1'b1);
        chk_txn("b2b.a0", 32'h000, 32'h0, 32'h80, 1'b0, 1'b0);
        #1 chk("b2b.a0_ready", 32'(seg_ready), 32'd0);
        tick();
        chk_txn("b2b.a1", 32'h080, 32'h0, 32'h80, 1'b1, 1'b0);
        #1 chk("b2b.a1_ready", 32'(seg_ready), 32'd1);
        tick();
        set_seg(1'b0, 32'h0, 8'd0, 8'h0, 1'b0);
        chk_txn("b2b.b0", 32'h380, 32'h7F, 32'h01, 1'b1, 1'b1);
        tick();
        chk("b2b.idle", 32'(txn_valid), 32'd0);

        // ---------------- address wrap ----------------
        set_seg(1'b1, 32'hFFFF_FF80, 8'd1, 8'h10, 1'b0);
        tick();
        set_seg(1'b0, 32'h0, 8'd0, 8'h0, 1'b0);
        chk_txn("wrap.t0", 32'hFFFF_FF80, 32'h0, 32'h80, 1'b0, 1'b0);
        tick();
        chk_txn("wrap.t1", 32'h0000_0000, 32'h0, 32'h10, 1'b1, 1'b0);
        tick();

        // ---------------- reset in the middle of ISSUE ----------------
        set_seg(1'b1, 32'h200, 8'd3, 8'h80, 1'b1);
        tick();
        set_seg(1'b0, 32'h0, 8'd0, 8'h0, 1'b0);
        tick();
        chk_txn("mid.t1", 32'h280, 32'h0, 32'h80, 1'b0, 1'b0);
        reset = 1'b1;
        #1;
        chk("mid.rst_valid", 32'(txn_valid), 32'd0);
        chk("mid.rst_busy",  32'(busy), 32'd0);
        chk("mid.rst_ready", 32'(seg_ready), 32'd0);
        chk("mid.rst_addr",  txn_addr, 32'd0);
        reset = 1'b0;
        set_seg(1'b1, 32'h505, 8'd1, 8'h07, 1'b0);
        #1 chk("mid.new_ready", 32'(seg_ready), 32'd1);
        tick();
        set_seg(1'b0, 32'h0, 8'd0, 8'h0, 1'b0);
        chk_txn("mid.n0", 32'h500, 32'h05, 32'h7B, 1'b0, 1'b0);
        tick();
        chk_txn("mid.n1", 32'h580, 32'h0, 32'h07, 1'b1, 1'b0);
        tick();
        chk("mid.idle", 32'(txn_valid), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/vlsu_txn_issuer.md
VLSU_TXN_ISSUER -- requirements
Module: vlsu_txn_issuer

Interface
REQ-001 SHALL have parameter VLSU_ADDR_BITS, default 32, the nibble-granular address width.
REQ-002 SHALL have parameter SLEN, default 512, the segment/page width in bits; P = SLEN/4 nibbles per page and NB = log2(P).
REQ-003 SHALL have parameter TXN_BITS, default 8, the width of the transaction index.
REQ-004 SHALL have port clock, input, 1, the single clock; all state on rising edge.
REQ-005 SHALL have port reset, input, 1, the reset; asynchronous, active-high.
REQ-006 SHALL have port seg_valid, input, 1, the segment descriptor is valid.
REQ-007 SHALL have port seg_ready, output, 1, the issuer accepts the descriptor.
REQ-008 SHALL have port seg_base_addr, input, VLSU_ADDR_BITS, the segment base nibble address.
REQ-009 SHALL have port seg_txn_num, input, TXN_BITS, the transactions in the segment minus 1.
REQ-010 SHALL have port seg_ltn, input, NB+1, the last-transaction end nibble count including page offset (1..P).
REQ-011 SHALL have port seg_final, input, 1, the segment is the last of the request.
REQ-012 SHALL have port txn_valid, output, 1, a transaction request is valid.
REQ-013 SHALL have port txn_ready, input, 1, downstream accepts the request.
REQ-014 SHALL have port txn_addr, output, VLSU_ADDR_BITS, the page-aligned nibble address (low NB bits zero).
REQ-015 SHALL have port txn_off, output, NB, the first valid nibble within the page.
REQ-016 SHALL have port txn_nbs, output, NB+1, the valid nibble count (1..P).
REQ-017 SHALL have port txn_last_seg, output, 1, the last transaction of the segment.
REQ-018 SHALL have port txn_final, output, 1, the last transaction of the request (txn_last_seg and latched seg_final).
REQ-019 SHALL have port busy, output, 1, the state is not IDLE.

Function
REQ-020 SHALL implement FSM states IDLE and ISSUE.
REQ-021 IDLE: seg_ready=1 and txn_valid=0; when seg_valid, the block latches the descriptor, sets cnt=0 and moves to ISSUE the next cycle.
REQ-022 ISSUE: txn_valid=1, driven from registers only, with no combinational path from seg_* to txn_*.
REQ-023 In ISSUE, txn_addr SHALL equal {base[hi:NB],0} + (cnt << NB), wrapping modulo 2^VLSU_ADDR_BITS.
REQ-024 txn_off SHALL equal base[NB-1:0] when cnt==0, else 0.
REQ-025 txn_nbs SHALL be: ltn-off for single transaction (num==0); P-off for first; ltn for last; P for middle.
REQ-026 txn_last_seg SHALL be asserted when cnt==num.
REQ-027 On fire (txn_valid&&txn_ready) with cnt!=num, cnt SHALL increment.
REQ-028 On fire with cnt==num, the block SHALL go to IDLE, unless seg_valid is high.
REQ-029 seg_ready SHALL equal IDLE || (fire && cnt==num); a descriptor accepted on the last fire loads directly with cnt=0, staying in ISSUE with no bubble.
REQ-030 While txn_valid && !txn_ready, all txn_* outputs SHALL hold stable.
REQ-031 seg_valid SHALL be ignored in ISSUE except on the last-fire cycle.
REQ-032 Throughput SHALL be one transaction per cycle under txn_ready=1; latency from seg accept to first txn_valid SHALL be 1 cycle.

Reset
REQ-033 On reset assertion, the block SHALL go to IDLE immediately, asynchronously, including mid-ISSUE; any in-flight segment is dropped.
REQ-034 Reset values SHALL be: txn_valid=0, busy=0, seg_ready=0 while reset is asserted then 1, cnt=0, and all txn_* data outputs 0.

Configuration
REQ-035 With VLSU_TXN_STALL_CNT_EN defined, the block SHALL add output stall_cnt, 32 bits, reset 0, incrementing each cycle txn_valid && !txn_ready and saturating at 0xFFFFFFFF.
REQ-036 Without VLSU_TXN_STALL_CNT_EN, the stall_cnt port and its logic SHALL be absent and behaviour is otherwise identical.

Verification
REQ-037 With P=128: base=0x105, num=0, ltn=0x45 -> one txn: addr 0x100, off 5, nbs 0x40, last_seg 1.
REQ-038 base=0x10A, num=2, ltn=0x20, final=1 -> three txns: addr 0x100/0x180/0x200, off 0x0A/0/0, nbs 0x76/0x80/0x20; only the third has last_seg=1 and final=1.
REQ-039 txn_ready low 3 cycles during the second txn of REQ-038 -> outputs stable, cnt unchanged; with the macro defined, stall_cnt=3.
REQ-040 Two descriptors presented back-to-back with txn_ready=1 -> the second is accepted on the last-fire cycle and its first txn appears the next cycle with no idle gap.
REQ-041 Reset asserted in the middle of ISSUE -> txn_valid=0 and busy=0 in the same cycle; after release, a new descriptor issues correctly from cnt=0.
